riscv_multicycle_ctrl: RTL and testbench

Multicycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback, and drives the immediate-type select for the immediate mux. It also drives the PC, instruction-register, register-file and memory control strobes. It sits between the instruction register and the datapath, with one instruction in flight at a time.

---
 rtl/riscv_multicycle_ctrl.sv | 175 +++++++++++++++++
 tb/tb_riscv_multicycle_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing.
// In: clk, rst_n, instr, mem_ready, branch_taken. Out: mem, pc, rf strobes, imm_sel, illegal, state.
module riscv_multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [2:0]  imm_sel,
  output logic        alu_src_b,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t     cs, ns;
  logic [2:0] imm_q, imm_d;
  logic [6:0] op;
  logic       is_load, is_opimm, is_auipc, is_store, is_op;
  logic       is_lui, is_branch, is_jalr, is_jal, legal;
  logic       wr, rd_nz;
  logic       unused;

  assign op        = instr[6:0];
  assign is_load   = op == OP_LOAD;
  assign is_opimm  = op == OP_OPIMM;
  assign is_auipc  = op == OP_AUIPC;
  assign is_store  = op == OP_STORE;
  assign is_op     = op == OP_OP;
  assign is_lui    = op == OP_LUI;
  assign is_branch = op == OP_BRANCH;
  assign is_jalr   = op == OP_JALR;
  assign is_jal    = op == OP_JAL;
  assign legal     = is_load | is_opimm | is_auipc
                   | is_store | is_op | is_lui
                   | is_branch | is_jalr | is_jal;
  assign rd_nz     = |instr[11:7];
  assign unused    = ^instr[31:12];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs    <= IDLE;
      imm_q <= 3'b000;
    end else begin
      cs    <= ns;
      imm_q <= imm_d;
    end
  end

  // OP and illegal opcodes leave the previous immediate type in place
  always_comb begin
    imm_d = imm_q;
    if (cs == DECODE) begin
      unique case (1'b1)
        is_load, is_opimm, is_jalr: imm_d = 3'b000;
        is_store:                   imm_d = 3'b001;
        is_branch:                  imm_d = 3'b010;
        is_jal:                     imm_d = 3'b011;
        is_lui, is_auipc:           imm_d = 3'b100;
        default:                    imm_d = imm_q;
      endcase
    end
  end

  always_comb begin
    ns = cs;
    unique case (cs)
      IDLE:   ns = FETCH;
      FETCH:  ns = mem_ready ? DECODE : FETCH;
      DECODE: ns = legal ? EXEC : FETCH;
      EXEC: begin
        unique case (1'b1)
          is_op, is_opimm, is_auipc: ns = WB;
          is_load, is_store:         ns = MEM;
          default:                   ns = FETCH;
        endcase
      end
      MEM: begin
        if (mem_ready)
          ns = is_store ? FETCH : WB;
      end
      WB:      ns = FETCH;
      default: ns = IDLE;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    alu_src_b    = 1'b0;
    wr           = 1'b0;
    wb_sel       = 2'b00;
    illegal      = 1'b0;
    unique case (cs)
      FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
      end
      DECODE: begin
        if (!legal) begin
          illegal  = 1'b1;
          pc_write = 1'b1;
        end
      end
      EXEC: begin
        alu_src_b = !(is_op | is_branch);
        unique case (1'b1)
          is_branch: begin
            pc_write = 1'b1;
            pc_src   = branch_taken ? 2'b01 : 2'b00;
          end
          is_jal, is_jalr: begin
            wr       = 1'b1;
            wb_sel   = 2'b10;
            pc_write = 1'b1;
            pc_src   = is_jal ? 2'b01 : 2'b10;
          end
          is_lui: begin
            wr       = 1'b1;
            wb_sel   = 2'b11;
            pc_write = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
        pc_write     = is_store & mem_ready;
      end
      WB: begin
        wr       = 1'b1;
        wb_sel   = is_load ? 2'b01 : 2'b00;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign reg_write = wr & rd_nz;
  assign imm_sel   = imm_q;
  assign state     = cs;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Table-driven bench for riscv_multicycle_ctrl.
// One vector per clock: inputs plus expected state, imm_sel and strobes.
module tb_riscv_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        mem_ready, branch_taken;
  logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
  logic [1:0]  pc_src, wb_sel;
  logic [2:0]  imm_sel, state;
  logic        alu_src_b, reg_write, illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  riscv_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .mem_ready(mem_ready), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src),
    .imm_sel(imm_sel), .alu_src_b(alu_src_b),
    .reg_write(reg_write), .wb_sel(wb_sel),
    .illegal(illegal), .state(state)
  );

  typedef struct {
    logic [31:0] i;
    logic        r;
    logic        b;
    logic [2:0]  st;
    logic [2:0]  im;
    logic [11:0] o;
  } vec_t;

  // {req,we,asel,irw}_{pcw,pcsrc}_{asb,rw}_{wbsel}_{ill}
  localparam logic [11:0] ZRO = 12'b0000_000_00_00_0;
  localparam logic [11:0] FRD = 12'b1001_000_00_00_0;
  localparam logic [11:0] FWT = 12'b1000_000_00_00_0;
  localparam logic [11:0] EXI = 12'b0000_000_10_00_0;
  localparam logic [11:0] WBA = 12'b0000_100_01_00_0;
  localparam logic [11:0] WB0 = 12'b0000_100_00_00_0;
  localparam logic [11:0] MSW = 12'b1110_000_00_00_0;
  localparam logic [11:0] MSD = 12'b1110_100_00_00_0;
  localparam logic [11:0] BRT = 12'b0000_101_00_00_0;
  localparam logic [11:0] BRN = 12'b0000_100_00_00_0;
  localparam logic [11:0] JAL = 12'b0000_101_11_10_0;
  localparam logic [11:0] JLR = 12'b0000_110_11_10_0;
  localparam logic [11:0] LUI = 12'b0000_100_11_11_0;
  localparam logic [11:0] ILL = 12'b0000_100_00_00_1;
  localparam logic [11:0] MLD = 12'b1010_000_00_00_0;
  localparam logic [11:0] WBL = 12'b0000_100_01_01_0;

  localparam logic [31:0] ADDI  = 32'h00500093;
  localparam logic [31:0] SW    = 32'h0020A423;
  localparam logic [31:0] BEQ   = 32'h00208463;
  localparam logic [31:0] JALI  = 32'h008000EF;
  localparam logic [31:0] LUII  = 32'h123452B7;
  localparam logic [31:0] ADD   = 32'h003100B3;
  localparam logic [31:0] BAD   = 32'hFFFFFFFF;
  localparam logic [31:0] ADDI0 = 32'h00500013;
  localparam logic [31:0] LW    = 32'h0040A183;
  localparam logic [31:0] JALRI = 32'h000100E7;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [31:0] i,
                              input logic r, input logic b,
                              input logic [2:0] st,
                              input logic [2:0] im,
                              input logic [11:0] o);
    vec_t v;
    v.i = i; v.r = r; v.b = b;
    v.st = st; v.im = im; v.o = o;
    return v;
  endfunction

  function automatic logic [11:0] outs();
    return {mem_req, mem_we, mem_addr_sel, ir_write,
            pc_write, pc_src, alu_src_b, reg_write,
            wb_sel, illegal};
  endfunction

  task automatic chk(input string nm, input int n,
                     input logic [11:0] got,
                     input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%h exp=%h", nm, n, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int n);
    instr = v.i;
    mem_ready = v.r;
    branch_taken = v.b;
    #1;
    chk("state", n, {9'd0, state}, {9'd0, v.st});
    chk("imm_sel", n, {9'd0, imm_sel}, {9'd0, v.im});
    chk("outs", n, outs(), v.o);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    instr = 32'h0;
    mem_ready = 1'b0;
    branch_taken = 1'b0;

    tbl.push_back(mk(ADDI, 1, 0, 0, 0, ZRO));
    tbl.push_back(mk(ADDI, 1, 0, 1, 0, FRD));
    tbl.push_back(mk(ADDI, 1, 0, 2, 0, ZRO));
    tbl.push_back(mk(ADDI, 1, 0, 3, 0, EXI));
    tbl.push_back(mk(ADDI, 1, 0, 5, 0, WBA));
    tbl.push_back(mk(SW,   1, 0, 1, 0, FRD));
    tbl.push_back(mk(SW,   1, 0, 2, 0, ZRO));
    tbl.push_back(mk(SW,   1, 0, 3, 1, EXI));
    tbl.push_back(mk(SW,   0, 0, 4, 1, MSW));
    tbl.push_back(mk(SW,   0, 0, 4, 1, MSW));
    tbl.push_back(mk(SW,   0, 0, 4, 1, MSW));
    tbl.push_back(mk(SW,   1, 0, 4, 1, MSD));
    tbl.push_back(mk(BEQ,  1, 1, 1, 1, FRD));
    tbl.push_back(mk(BEQ,  1, 1, 2, 1, ZRO));
    tbl.push_back(mk(BEQ,  1, 1, 3, 2, BRT));
    tbl.push_back(mk(BEQ,  1, 0, 1, 2, FRD));
    tbl.push_back(mk(BEQ,  1, 0, 2, 2, ZRO));
    tbl.push_back(mk(BEQ,  1, 0, 3, 2, BRN));
    tbl.push_back(mk(JALI, 1, 0, 1, 2, FRD));
    tbl.push_back(mk(JALI, 1, 0, 2, 2, ZRO));
    tbl.push_back(mk(JALI, 1, 0, 3, 3, JAL));
    tbl.push_back(mk(LUII, 1, 0, 1, 3, FRD));
    tbl.push_back(mk(LUII, 1, 0, 2, 3, ZRO));
    tbl.push_back(mk(LUII, 1, 0, 3, 4, LUI));
    tbl.push_back(mk(ADD,  1, 0, 1, 4, FRD));
    tbl.push_back(mk(ADD,  1, 0, 2, 4, ZRO));
    tbl.push_back(mk(ADD,  1, 0, 3, 4, ZRO));
    tbl.push_back(mk(ADD,  1, 0, 5, 4, WBA));
    tbl.push_back(mk(BAD,  1, 0, 1, 4, FRD));
    tbl.push_back(mk(BAD,  1, 0, 2, 4, ILL));
    tbl.push_back(mk(ADDI0,0, 0, 1, 4, FWT));
    tbl.push_back(mk(ADDI0,1, 0, 1, 4, FRD));
    tbl.push_back(mk(ADDI0,1, 0, 2, 4, ZRO));
    tbl.push_back(mk(ADDI0,1, 0, 3, 0, EXI));
    tbl.push_back(mk(ADDI0,1, 0, 5, 0, WB0));
    tbl.push_back(mk(LW,   1, 0, 1, 0, FRD));
    tbl.push_back(mk(LW,   1, 0, 2, 0, ZRO));
    tbl.push_back(mk(LW,   1, 0, 3, 0, EXI));
    tbl.push_back(mk(LW,   1, 0, 4, 0, MLD));
    tbl.push_back(mk(LW,   1, 0, 5, 0, WBL));
    tbl.push_back(mk(BEQ,  1, 0, 1, 0, FRD));
    tbl.push_back(mk(BEQ,  1, 0, 2, 0, ZRO));
    tbl.push_back(mk(BEQ,  1, 0, 3, 2, BRN));
    tbl.push_back(mk(JALRI,1, 0, 1, 2, FRD));
    tbl.push_back(mk(JALRI,1, 0, 2, 2, ZRO));
    tbl.push_back(mk(JALRI,1, 0, 3, 0, JLR));
    tbl.push_back(mk(SW,   1, 0, 1, 0, FRD));
    tbl.push_back(mk(SW,   1, 0, 2, 0, ZRO));
    tbl.push_back(mk(SW,   1, 0, 3, 1, EXI));
    tbl.push_back(mk(SW,   0, 0, 4, 1, MSW));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", -1, {9'd0, state}, 12'd0);
    chk("rst_imm", -1, {9'd0, imm_sel}, 12'd0);
    chk("rst_outs", -1, outs(), ZRO);
    rst_n = 1'b1;

    foreach (tbl[k]) apply(tbl[k], k);

    // Still stalled in MEM; drop reset before the edge
    instr = SW;
    mem_ready = 1'b0;
    #1;
    chk("pre_state", 100, {9'd0, state}, 12'd4);
    rst_n = 1'b0;
    #1;
    chk("async_state", 101, {9'd0, state}, 12'd0);
    chk("async_imm", 101, {9'd0, imm_sel}, 12'd0);
    chk("async_outs", 101, outs(), ZRO);
    @(negedge clk);
    chk("hold_outs", 102, outs(), ZRO);
    rst_n = 1'b1;
    apply(mk(ADDI, 1, 0, 0, 0, ZRO), 103);
    apply(mk(ADDI, 1, 0, 1, 0, FRD), 104);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
